// File: rtl/num_calc_pkg.sv
// num_calc_pkg: opcodes and FSM state encoding shared by the num_calc blocks
package num_calc_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/num_calc_div.sv
// num_calc_div: restoring divider, one quotient bit per cycle, MSB first
module num_calc_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, src_rem, src_quo, src_dvs, rem_d, quo_d;
    logic [WIDTH:0]   shifted, diff;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;

    // One restoring step; the start cycle already resolves the first bit from the raw operands
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        shifted = {src_rem, src_quo[WIDTH-1]};
        diff    = shifted - {1'b0, src_dvs};
        rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d   = {src_quo[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Iteration state; done is raised by the last of the WIDTH steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= divisor;
            cnt_q  <= CW'(WIDTH - 1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q - 1'b1;
            busy_q <= cnt_q != CW'(1);
            done_q <= cnt_q == CW'(1);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/num_calc_seq.sv
// num_calc_seq: sequential arithmetic unit with valid/ready handshake and iterative div/mod
module num_calc_seq
    import num_calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               dz
);
    state_t               state_q, state_d;
    logic                 rdy_q, is_mod_q, dz_q, dz_d;
    logic [2*WIDTH-1:0]   result_q, result_d, alu_res, ax, bx;
    logic                 accept, is_div_op, div_start, div_busy, div_done;
    logic [WIDTH-1:0]     quo, rem;

    assign ax        = {{WIDTH{1'b0}}, a};
    assign bx        = {{WIDTH{1'b0}}, b};
    assign accept    = in_valid && in_ready;
    assign is_div_op = (op == OP_DIV) || (op == OP_MOD);
    assign div_start = accept && is_div_op && (b != '0);

    num_calc_div #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (a),
        .divisor  (b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo),
        .remainder(rem)
    );

    // Single-cycle results; DIV/MOD entries only matter for the divide-by-zero bypass
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = ax + bx;
            OP_SUB:  alu_res = {{(WIDTH-1){1'b0}}, a < b, a - b};
            OP_MUL:  alu_res = ax * bx;
            OP_DIV:  alu_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
            OP_MOD:  alu_res = ax;
            OP_AND:  alu_res = ax & bx;
            OP_OR:   alu_res = ax | bx;
            OP_XOR:  alu_res = ax ^ bx;
            default: alu_res = '0;
        endcase
    end

    // State register; rdy_q keeps in_ready low until the first clock after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = div_start ? ST_DIV : ST_DONE;
            ST_DIV:  if (div_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so no input reaches a handshake output combinationally
    always_comb begin
        in_ready  = rdy_q && (state_q == ST_IDLE) && !div_busy;
        out_valid = state_q == ST_DONE;
    end

    // Result capture: immediate ops at acceptance, divider output when it finishes
    always_comb begin
        result_d = result_q;
        dz_d     = dz_q;
        if (accept && !div_start) begin
            result_d = alu_res;
            dz_d     = is_div_op;
        end else if (state_q == ST_DIV && div_done) begin
            result_d = {{WIDTH{1'b0}}, is_mod_q ? rem : quo};
            dz_d     = 1'b0;
        end
    end

    // Result registers, held stable through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            dz_q     <= 1'b0;
            is_mod_q <= 1'b0;
        end else begin
            result_q <= result_d;
            dz_q     <= dz_d;
            is_mod_q <= accept ? (op == OP_MOD) : is_mod_q;
        end
    end

    assign result = result_q;
    assign dz     = dz_q;

endmodule

// File: tb/tb_num_calc_seq.sv
// tb_num_calc_seq: directed and randomized scoreboard bench for num_calc_seq at WIDTH 8 and 3
module tb_num_calc_seq;

    logic        clk, rst_n;
    logic        iv8, ir8, ov8, or8, dz8;
    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic [15:0] res8;
    logic        iv3, ir3, ov3, or3, dz3;
    logic [2:0]  a3, b3, op3;
    logic [5:0]  res3;

    logic [16:0] q8[$];
    logic [16:0] q3[$];
    int tests = 0;
    int fails = 0;

    num_calc_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
        .out_valid(ov8), .out_ready(or8), .result(res8), .dz(dz8)
    );

    num_calc_seq #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .op(op3),
        .out_valid(ov3), .out_ready(or3), .result(res3), .dz(dz3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] model(input int w, input int ai, input int bi, input int op);
        int m, r;
        logic z;
        m = (1 << w) - 1;
        z = 1'b0;
        case (op)
            0: r = ai + bi;
            1: r = ((ai - bi) & m) | ((ai < bi) ? (1 << w) : 0);
            2: r = ai * bi;
            3: if (bi == 0) begin r = m; z = 1'b1; end else r = ai / bi;
            4: if (bi == 0) begin r = ai; z = 1'b1; end else r = ai % bi;
            5: r = ai & bi;
            6: r = ai | bi;
            default: r = ai ^ bi;
        endcase
        return {z, r[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int exp_lat, input string tag);
        int lat;
        logic [16:0] e;
        @(posedge clk); #1;
        iv8 = 1'b1; a8 = a; b8 = b; op8 = op;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(ir8), 32'd1);
        @(posedge clk);
        q8.push_back(model(8, int'(a), int'(b), int'(op)));
        #1;
        iv8 = 1'b0; a8 = ~a; b8 = ~b; op8 = op + 3'd1;
        lat = 1;
        @(negedge clk);
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        e = q8.pop_front();
        chk(tag, {15'd0, dz8, res8}, {15'd0, e});
        @(posedge clk); #1;
        chk({tag, "_hs"}, 32'(ov8), 32'd0);
    endtask

    task automatic txn3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
        int lat, exp_lat;
        logic [16:0] e;
        exp_lat = ((op == 3'd3 || op == 3'd4) && b != 3'd0) ? 4 : 1;
        @(posedge clk); #1;
        iv3 = 1'b1; a3 = a; b3 = b; op3 = op;
        @(posedge clk);
        q3.push_back(model(3, int'(a), int'(b), int'(op)));
        #1;
        iv3 = 1'b0; a3 = ~a; b3 = ~b; op3 = ~op;
        lat = 1;
        @(negedge clk);
        while (!ov3 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = q3.pop_front();
        chk($sformatf("w3_lat op%0d a%0d b%0d", op, a, b), 32'(lat), 32'(exp_lat));
        chk($sformatf("w3_res op%0d a%0d b%0d", op, a, b), {25'd0, dz3, res3}, {25'd0, e[16], e[5:0]});
        @(posedge clk);
    endtask

    initial begin
        logic [16:0] e;
        int seen;
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; or8 = 1'b1;
        iv3 = 1'b0; a3 = '0; b3 = '0; op3 = '0; or3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(ir8), 32'd0);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_result", 32'(res8), 32'd0);
        chk("rst_dz", 32'(dz8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(ir8), 32'd1);

        txn8(8'd200, 8'd100, 3'd0, 1, "add");
        txn8(8'd5,   8'd7,   3'd1, 1, "sub");
        txn8(8'd255, 8'd255, 3'd2, 1, "mul");
        txn8(8'd100, 8'd7,   3'd3, 9, "div");
        txn8(8'd100, 8'd7,   3'd4, 9, "mod");
        txn8(8'd0,   8'd5,   3'd3, 9, "div_zero_num");
        txn8(8'd77,  8'd0,   3'd3, 1, "div_by_zero");
        txn8(8'd77,  8'd0,   3'd4, 1, "mod_by_zero");
        txn8(8'hC3,  8'h5A,  3'd5, 1, "and");
        txn8(8'hC3,  8'h5A,  3'd6, 1, "or");

        @(posedge clk); #1;
        or8 = 1'b0; iv8 = 1'b1; a8 = 8'hA5; b8 = 8'h0F; op8 = 3'd7;
        @(posedge clk);
        q8.push_back(model(8, 'hA5, 'h0F, 7));
        #1;
        a8 = 8'd3; b8 = 8'd4; op8 = 3'd0;
        e = q8.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(ov8), 32'd1);
            chk("bp_result", {15'd0, dz8, res8}, {15'd0, e});
            chk("bp_in_ready", 32'(ir8), 32'd0);
        end
        @(posedge clk); #1;
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", {30'd0, ir8, ov8}, 32'd2);
        @(posedge clk);
        q8.push_back(model(8, 3, 4, 0));
        #1;
        iv8 = 1'b0;
        @(negedge clk);
        e = q8.pop_front();
        chk("bp_next_valid", 32'(ov8), 32'd1);
        chk("bp_next_add", {15'd0, dz8, res8}, {15'd0, e});
        @(posedge clk);

        @(posedge clk); #1;
        iv8 = 1'b1; a8 = 8'd200; b8 = 8'd3; op8 = 3'd3;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(ov8), 32'd0);
        chk("midrst_in_ready", 32'(ir8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov8) seen++;
        end
        chk("midrst_no_output", 32'(seen), 32'd0);
        chk("midrst_idle", 32'(ir8), 32'd1);
        txn8(8'd1, 8'd1, 3'd0, 1, "add_after_rst");

        for (int i = 0; i < 500; i++)
            txn3(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/num_calc_seq.md
# num_calc_seq

Parametrised, sequential successor to the team's combinational 3-bit `num_calculation` unit. It accepts one unsigned operand pair plus an opcode per transaction over a valid/ready handshake. Single-cycle ops (add, sub, mul, logic) return after one cycle; div/mod run on an iterative restoring divider. It sits between a stimulus or register source and a consumer that can apply backpressure.

## Interface
- `WIDTH`, default 8: operand width in bits, ≥2.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  block can accept a request
- `a`  in  WIDTH  operand A, unsigned
- `b`  in  WIDTH  operand B, unsigned
- `op`  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `result`  out  2*WIDTH  result, zero-extended
- `dz`  out  1  divide-by-zero flag, qualified by `out_valid`

## Operation
- FSM states: IDLE, DIV, DONE. Reset state is IDLE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, capture `a`, `b`, `op`.
  - Non-div ops: compute, register into `result`, go to DONE.
  - DIV/MOD with `b`≠0: load the divider, set iteration counter = WIDTH, go to DIV.
  - DIV/MOD with `b`==0: `result` = all-ones in the low WIDTH bits for DIV, `a` for MOD. Set `dz`=1 and go to DONE.
- DIV: one quotient bit per cycle, MSB first (restoring). Counter decrements each cycle. When the counter reaches 0, load quotient (DIV) or remainder (MOD) into `result`, `dz`=0, go to DONE.
- DONE: `out_valid`=1 and `result`/`dz` are held stable. On `out_ready`, go to IDLE.
- `in_ready`=0 in DIV and DONE, so only one transaction is in flight.
- Arithmetic, all unsigned:
  - ADD: WIDTH+1-bit sum.
  - SUB: bits [WIDTH-1:0] = (a−b) mod 2^WIDTH; bit WIDTH = borrow (a<b).
  - MUL: full 2*WIDTH product.
  - Logic ops: WIDTH bits.
  - All unused upper bits are 0.
- Inputs `a`/`b`/`op` are sampled only at acceptance. Later changes have no effect.
- Reset mid-operation (any state): returns to IDLE immediately and discards the transaction. No `out_valid` is produced for it.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0, then 1 (IDLE). `out_valid`=0, `result`=0, `dz`=0.
- Latency is measured from the acceptance edge:
  - Non-div or div-by-zero: `out_valid` high in the next cycle (1 cycle).
  - DIV/MOD: `out_valid` high WIDTH+1 cycles after acceptance.
- `out_valid` stays high until the cycle `out_ready`=1. The handshake completes on that edge.
- The next request can be accepted no earlier than the cycle after the output handshake. Minimum issue interval is 2 cycles (non-div) or WIDTH+2 cycles (div).
- `out_ready` is ignored when `out_valid`=0.
- There is no combinational path from `in_valid` to `in_ready`, nor from `out_ready` to `out_valid`.

## Structure
- Shared package `num_calc_pkg`:
  - opcode localparams `OP_ADD` … `OP_XOR` (3-bit);
  - FSM state encoding `ST_IDLE`, `ST_DIV`, `ST_DONE`.
- Sub-module `num_calc_div`: WIDTH-parametrised restoring divider.
  - Ports: `clk`, `rst_n`, `start`, `dividend`, `divisor`, `busy`, `done`, `quotient`, `remainder`.
  - `done` pulses for one cycle WIDTH cycles after `start`.
  - The top FSM owns the handshake and the divide-by-zero bypass.
- Expected size: ~250 lines total.

## Test plan
WIDTH=8 unless stated.
- Reset/ADD: `rst_n` low for 3 cycles, then check all reset values. ADD 200+100, `out_ready`=1 → `result`=300 (0x012C) one cycle after acceptance, `dz`=0.
- SUB/MUL: SUB 5−7 → `result`=0x01FE (borrow set). MUL 255×255 → `result`=65025 (0xFE01).
- Division: DIV 100/7 → `result`=14, `out_valid` exactly 9 cycles after acceptance. MOD 100%7 → 2. DIV 0/5 → 0.
- Divide by zero: DIV 77/0 → `result`=0x00FF, `dz`=1, 1-cycle latency. MOD 77/0 → `result`=77, `dz`=1.
- Backpressure: XOR 0xA5^0x0F with `out_ready`=0 for 5 cycles → `result`=0xAA held stable, `out_valid` high throughout, `in_ready`=0. A new `in_valid` offered meanwhile is not accepted. It is accepted the cycle after `out_ready`=1.
- Reset mid-division, plus a WIDTH=3 regression:
  - Assert `rst_n`=0 four cycles into DIV 200/3 → `out_valid` stays 0, state returns to IDLE, and a following ADD 1+1 → 2.
  - Re-run with WIDTH=3, randomized `a`, `b`, `op` for 500 transactions, checked against a reference model.
